// File: rtl/rx_frame_checker.sv
// Receive-frame checker: verifies each decoded frame against an incrementing word
// sequence starting at SEED, tracks decoder error flags and keeps pass/fail counters.
module rx_frame_checker #(
    parameter logic [15:0] SEED    = 16'h7EC3,
    parameter logic [15:0] TIMEOUT = 16'd48000
) (
    input  logic        clk_24M,
    input  logic        rst,
    input  logic [6:0]  frame_length,
    input  logic        word_valid,
    input  logic [15:0] word_data,
    input  logic        frame_over,
    input  logic [4:0]  err_in,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt,
    output logic [7:0]  status,
    output logic [15:0] led
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_CLOSE = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [15:0] exp_q,     exp_d;
    logic [6:0]  cnt_q,     cnt_d;
    logic        mis_q,     mis_d;
    logic        tmo_q,     tmo_d;
    logic [4:0]  sticky_q,  sticky_d;
    logic [15:0] gap_q,     gap_d;
    logic [15:0] ok_cnt_q,  ok_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [7:0]  status_q,  status_d;
    logic        done_q,    done_d;
    logic        fok_q,     fok_d;
    logic [15:0] led_q,     led_d;
    logic [15:0] gap_inc_s;
    logic        pass_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            sat_inc16 = v;
        end else begin
            sat_inc16 = v + 16'd1;
        end
    endfunction

    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        if (v == 7'd127) begin
            sat_inc7 = v;
        end else begin
            sat_inc7 = v + 7'd1;
        end
    endfunction

    assign gap_inc_s = gap_q + 16'd1;
    assign pass_s    = !mis_q && !tmo_q && (sticky_q == 5'd0) && (cnt_q == frame_length);

    // Next-state and datapath decode for the frame FSM
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        cnt_d     = cnt_q;
        mis_d     = mis_q;
        tmo_d     = tmo_q;
        sticky_d  = sticky_q;
        gap_d     = gap_q;
        ok_cnt_d  = ok_cnt_q;
        err_cnt_d = err_cnt_q;
        status_d  = status_q;
        done_d    = 1'b0;
        fok_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                exp_d    = SEED;
                cnt_d    = 7'd0;
                mis_d    = 1'b0;
                tmo_d    = 1'b0;
                sticky_d = 5'd0;
                gap_d    = 16'd0;
                if (word_valid) begin
                    mis_d    = (word_data != SEED);
                    cnt_d    = 7'd1;
                    exp_d    = SEED + 16'd1;
                    sticky_d = err_in;
                    if (frame_over) begin
                        state_d = ST_CLOSE;
                    end else begin
                        state_d = ST_RECV;
                    end
                end else if (frame_over) begin
                    sticky_d = err_in;
                    state_d  = ST_CLOSE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RECV: begin
                sticky_d = sticky_q | err_in;
                if (word_valid) begin
                    mis_d = mis_q | (word_data != exp_q);
                    exp_d = exp_q + 16'd1;
                    cnt_d = sat_inc7(cnt_q);
                    gap_d = 16'd0;
                end else begin
                    gap_d = gap_inc_s;
                end
                // A word arriving with frame_over is already counted above
                if (frame_over) begin
                    state_d = ST_CLOSE;
                end else if (!word_valid && (gap_inc_s == TIMEOUT)) begin
                    tmo_d   = 1'b1;
                    state_d = ST_CLOSE;
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_CLOSE: begin
                done_d   = 1'b1;
                fok_d    = pass_s;
                status_d = {sticky_q, tmo_q, (cnt_q != frame_length), mis_q};
                if (pass_s) begin
                    ok_cnt_d = sat_inc16(ok_cnt_q);
                end else begin
                    err_cnt_d = sat_inc16(err_cnt_q);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign led_d = {ok_cnt_d[7:0], status_d};

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_24M) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            exp_q     <= SEED;
            cnt_q     <= 7'd0;
            mis_q     <= 1'b0;
            tmo_q     <= 1'b0;
            sticky_q  <= 5'd0;
            gap_q     <= 16'd0;
            ok_cnt_q  <= 16'd0;
            err_cnt_q <= 16'd0;
            status_q  <= 8'd0;
            done_q    <= 1'b0;
            fok_q     <= 1'b0;
            led_q     <= 16'd0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            cnt_q     <= cnt_d;
            mis_q     <= mis_d;
            tmo_q     <= tmo_d;
            sticky_q  <= sticky_d;
            gap_q     <= gap_d;
            ok_cnt_q  <= ok_cnt_d;
            err_cnt_q <= err_cnt_d;
            status_q  <= status_d;
            done_q    <= done_d;
            fok_q     <= fok_d;
            led_q     <= led_d;
        end
    end

    assign frame_done = done_q;
    assign frame_ok   = fok_q;
    assign ok_cnt     = ok_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign status     = status_q;
    assign led        = led_q;

endmodule

// File: doc/rx_frame_checker.md
RX_FRAME_CHECKER -- requirements
Module: rx_frame_checker

Interface
REQ-001 Parameter SEED, default 16'h7EC3, SHALL be the expected value of word 0 of every received frame.
REQ-002 Parameter TIMEOUT, default 16'd48000, SHALL be the idle-gap cycle limit (2 ms at 24 MHz) between words inside a frame.
REQ-003 clk_24M  input  1  SHALL be the clock; all logic on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 frame_length  input  7  SHALL give the expected word count per frame.
REQ-006 word_valid  input  1  SHALL be a one-cycle strobe marking word_data valid (decoder data_get).
REQ-007 word_data  input  16  SHALL carry the decoded word.
REQ-008 frame_over  input  1  SHALL be a one-cycle strobe marking end of frame from the decoder.
REQ-009 err_in  input  5  SHALL carry decoder flags {length, signal, delimiter, quality, crc}, MSB to LSB.
REQ-010 frame_done  output  1  SHALL pulse for one cycle when a frame verdict is produced.
REQ-011 frame_ok  output  1  SHALL be high with frame_done when the frame passed.
REQ-012 ok_cnt, err_cnt  output  16 each  SHALL count passed and failed frames.
REQ-013 status  output  8  SHALL hold the last frame's failure bits.
REQ-014 led  output  16  SHALL equal {ok_cnt[7:0], status}.

Function
REQ-015 FSM states SHALL be IDLE, RECV, CLOSE.
REQ-016 In IDLE: expected word = SEED, word count = 0, sticky flags = 0, gap counter = 0.
REQ-017 IDLE + word_valid: compare word_data to SEED, word count = 1, expected = SEED+1, go RECV.
REQ-018 RECV + word_valid: mismatch flag sets if word_data != expected; expected increments mod 2^16 (16'hFFFF wraps to 0); word count increments, saturating at 127; gap counter clears.
REQ-019 RECV without word_valid: gap counter increments; at TIMEOUT, set timeout flag, go CLOSE.
REQ-020 RECV + frame_over: go CLOSE; a word_valid in the same cycle SHALL be compared and counted first.
REQ-021 err_in bits SHALL be OR-latched into sticky flags every cycle in IDLE-to-RECV transition, RECV and the frame_over cycle.
REQ-022 IDLE + frame_over with no word: go CLOSE with word count 0 (empty frame).
REQ-023 CLOSE (exactly one cycle): pass = no mismatch, no timeout, no sticky err_in, word count == frame_length; pulse frame_done, frame_ok = pass; go IDLE.
REQ-024 status bits: [0] mismatch, [1] count != frame_length, [2] timeout, [7:3] sticky err_in {length, signal, delimiter, quality, crc} as bits 7..3; status updates only in CLOSE.
REQ-025 In CLOSE: ok_cnt increments on pass, err_cnt otherwise; both saturate at 16'hFFFF.
REQ-026 Verdict latency: frame_done SHALL assert exactly 1 cycle after frame_over is sampled, or 1 cycle after the timeout cycle.
REQ-027 frame_over or word_valid arriving during CLOSE SHALL be ignored.
REQ-028 frame_ok SHALL be 0 whenever frame_done is 0.

Reset
REQ-029 rst low at a clock edge SHALL force IDLE, ok_cnt = 0, err_cnt = 0, status = 0, frame_done = 0, frame_ok = 0, led = 0, regardless of state; a partial frame is discarded with no verdict.
REQ-030 Outputs SHALL hold reset values for the first edge after rst returns high.

Verification
REQ-031 frame_length=16, words 7EC3..7ED2 every 8 cycles, then frame_over -> frame_done+frame_ok 1 cycle later, ok_cnt=1, status=8'h00.
REQ-032 Same frame with word 5 = 16'h0000 -> frame_ok=0, err_cnt=1, status=8'h01.
REQ-033 frame_length=16, 15 correct words + frame_over, err_in crc pulse mid-frame -> status=8'h0A, err_cnt=1.
REQ-034 SEED=16'hFFFE, 4 words FFFE,FFFF,0000,0001, frame_length=4 -> pass (wrap-around).
REQ-035 3 words then silence, TIMEOUT=100 -> frame_done 101 cycles after last word, status=8'h06.
REQ-036 rst low mid-frame after 8 words, then full good frame -> no verdict for partial; ok_cnt=1, err_cnt=0.
